arbiter_spec_monitor_n: RTL and testbench



---
 rtl/arbiter_spec_monitor_n.sv | 90 +++++++++
 tb/tb_arbiter_spec_monitor_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_spec_monitor_n.sv
// Safety/fairness error monitor for an N-client arbiter spec.
// Flags grant/master mismatch, mutex and range faults, and starvation.
module arbiter_spec_monitor_n #(
    parameter int N_CLIENTS  = 4,
    parameter int MASTER_W   = $clog2(N_CLIENTS),
    parameter int FAIR_BOUND = 8,
    parameter int CNT_W      = $clog2(FAIR_BOUND + 1),
    parameter bit STICKY     = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ready,
    input  logic [N_CLIENTS-1:0] i_req,
    input  logic [N_CLIENTS-1:0] controllable_grant,
    input  logic [MASTER_W-1:0]  controllable_master,
    output logic                 o_err,
    output logic                 o_err_safety,
    output logic                 o_err_fair,
    output logic [N_CLIENTS-1:0] o_fair_done
);

    localparam logic [CNT_W-1:0]    BOUND = CNT_W'(FAIR_BOUND);
    localparam logic [MASTER_W:0]   N_EXT = (MASTER_W + 1)'(N_CLIENTS);
    localparam logic [N_CLIENTS-1:0] ONE  = N_CLIENTS'(1);

    logic                 ready_q;
    logic [N_CLIENTS-1:0] grant_q;
    logic [N_CLIENTS-1:0] done_q, done_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    logic [N_CLIENTS-1:0] client_bad;
    logic [N_CLIENTS-1:0] fair;
    logic                 range_bad;
    logic                 mutex_bad;
    logic                 err_now;

    always_comb begin
        client_bad = '0;
        fair       = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            client_bad[i] = grant_q[i]
                != (controllable_master == MASTER_W'(i));
            fair[i] = (controllable_master != MASTER_W'(i))
                | ~i_req[i];
        end
    end

    assign range_bad = {1'b0, controllable_master} >= N_EXT;
    // More than one bit set iff clearing the lowest set bit leaves any.
    assign mutex_bad = |(grant_q & (grant_q - ONE));

    assign o_err_safety = ready_q
        & (|client_bad | range_bad | mutex_bad);
    assign o_err_fair   = cnt_q >= BOUND;
    assign o_fair_done  = done_q;
    assign err_now      = o_err_safety | o_err_fair;
    assign o_err        = err_now | err_q;

    always_comb begin
        done_d = done_q;
        cnt_d  = cnt_q;
        err_d  = STICKY ? (err_q | err_now) : 1'b0;
        if (&done_q) begin
            done_d = '0;
        end else if (|(fair & ~done_q)) begin
            done_d = done_q | fair;
            cnt_d  = '0;
        end else if (cnt_q < BOUND) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ready_q <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= i_ready;
            grant_q <= controllable_grant;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_arbiter_spec_monitor_n.sv
// Directed scoreboard bench for arbiter_spec_monitor_n.
// Covers a 4-client plain monitor, a sticky copy and a 3-client copy.
module tb_arbiter_spec_monitor_n;

    logic       clk;
    logic       rst_n;
    logic       ready;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] master;
    logic [2:0] grant3;
    logic [1:0] master3;
    logic [2:0] req3;

    logic       e4, s4, f4;
    logic [3:0] d4;
    logic       es, ss, fs;
    logic [3:0] ds;
    logic       e3, s3, f3;
    logic [2:0] d3;

    int n_vec;
    int n_err;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    arbiter_spec_monitor_n #(.N_CLIENTS(4)) u_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ready(ready),
        .i_req(req), .controllable_grant(grant),
        .controllable_master(master),
        .o_err(e4), .o_err_safety(s4),
        .o_err_fair(f4), .o_fair_done(d4)
    );

    arbiter_spec_monitor_n #(.N_CLIENTS(4), .STICKY(1'b1)) u_ds (
        .i_clk(clk), .i_rst_n(rst_n), .i_ready(ready),
        .i_req(req), .controllable_grant(grant),
        .controllable_master(master),
        .o_err(es), .o_err_safety(ss),
        .o_err_fair(fs), .o_fair_done(ds)
    );

    arbiter_spec_monitor_n #(.N_CLIENTS(3), .MASTER_W(2)) u_d3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_ready(ready),
        .i_req(req3), .controllable_grant(grant3),
        .controllable_master(master3),
        .o_err(e3), .o_err_safety(s3),
        .o_err_fair(f3), .o_fair_done(d3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return {31'd0, e4};
            1: return {31'd0, s4};
            2: return {31'd0, f4};
            3: return {28'd0, d4};
            4: return {31'd0, es};
            5: return {31'd0, ss};
            6: return {31'd0, s3};
            default: return 32'hdead;
        endcase
    endfunction

    task automatic expect_v(input string tag, input int sel,
                            input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        logic [31:0] o;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            n_vec++;
            assert (o === e.exp) else begin
                n_err++;
                $error("FAIL %s observed=%0h expected=%0h",
                       e.tag, o, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        ready   = 1'b0;
        req     = 4'b0000;
        grant   = 4'b0000;
        master  = 2'd0;
        grant3  = 3'b000;
        master3 = 2'd0;
        req3    = 3'b000;
        #1;
        expect_v("rst_err", 0, 0);
        expect_v("rst_safety", 1, 0);
        expect_v("rst_fair", 2, 0);
        expect_v("rst_done", 3, 0);
        expect_v("rst_sticky_err", 4, 0);
        check();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // grant sampled, master matches next cycle
        ready = 1'b1;
        grant = 4'b0100;
        tick();
        master = 2'd2;
        expect_v("match_err", 0, 0);
        expect_v("match_safety", 1, 0);
        check();
        master = 2'd1;
        expect_v("mismatch_safety", 1, 1);
        expect_v("mismatch_err", 0, 1);
        expect_v("mismatch_sticky", 4, 1);
        check();

        ready  = 1'b0;
        grant  = 4'b0000;
        master = 2'd0;
        tick();
        expect_v("after_err", 0, 0);
        expect_v("sticky_held", 4, 1);
        expect_v("sticky_safety_low", 5, 0);
        check();
        tick();
        expect_v("sticky_held2", 4, 1);
        check();
        rst_n = 1'b0;
        expect_v("async_rst_sticky", 4, 0);
        expect_v("async_rst_done", 3, 0);
        check();
        rst_n = 1'b1;
        tick();

        // multiple grants
        ready  = 1'b1;
        grant  = 4'b0110;
        master = 2'd1;
        tick();
        expect_v("mutex_safety", 1, 1);
        check();
        ready = 1'b0;
        tick();
        expect_v("mutex_not_ready", 1, 0);
        expect_v("mutex_not_ready_err", 0, 0);
        check();

        // master out of range on 3-client copy
        grant  = 4'b0000;
        master = 2'd0;
        ready  = 1'b1;
        grant3 = 3'b100;
        tick();
        master3 = 2'd2;
        expect_v("n3_ok", 6, 0);
        check();
        grant3 = 3'b000;
        tick();
        master3 = 2'd3;
        expect_v("n3_range", 6, 1);
        check();
        ready   = 1'b0;
        master3 = 2'd0;
        tick();
        expect_v("n3_not_ready", 6, 0);
        check();

        // starvation of client 0
        rst_n = 1'b0;
        #1;
        rst_n  = 1'b1;
        req    = 4'b1111;
        master = 2'd0;
        tick();
        expect_v("fair_done_1110", 3, 4'b1110);
        expect_v("fair_low_e1", 2, 0);
        check();
        for (int k = 0; k < 7; k++) begin
            tick();
            expect_v("fair_counting", 2, 0);
            check();
        end
        tick();
        expect_v("fair_bound_hit", 2, 1);
        expect_v("fair_drives_err", 0, 1);
        check();
        for (int k = 0; k < 20; k++) begin
            tick();
            expect_v("fair_saturated", 2, 1);
            check();
        end
        master = 2'd1;
        tick();
        expect_v("progress_done", 3, 4'b1111);
        expect_v("progress_fair", 2, 0);
        expect_v("progress_err", 0, 0);
        check();
        tick();
        expect_v("clear_wins", 3, 4'b0000);
        expect_v("clear_fair", 2, 0);
        check();
        tick();
        expect_v("reeval_done", 3, 4'b1101);
        check();

        // every obligation met on one edge
        req = 4'b0000;
        tick();
        expect_v("all_met", 3, 4'b1111);
        check();
        tick();
        expect_v("all_clear", 3, 4'b0000);
        expect_v("all_clear_fair", 2, 0);
        check();

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
